// File: rtl/exec_forward_stage.sv
// exec_forward_stage
// Execute stage of the 5-bit-register MIPS-style pipeline. Picks each ALU
// operand from the register file or from one of the three result history
// registers (r1/r2/r3), runs the ALU, and registers the result together with
// the data-memory controls for the following stage.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   op_dec[5:0]           opcode of the instruction in EX
//   imm[15:0], imm_sel    immediate (sign-extended) and operand-B select
//   mux_sel_A/B[1:0]      operand source: 00 rf, 01 r1, 10 r2, 11 r3
//   rf_data_A/B[DW-1:0]   register-file read data
//   mem_en_ex, mem_rw_ex  memory enable / write for the EX instruction
//   dm_load, dm_rdata     load flag and read data for the instruction in r1
//   flush                 turns the EX instruction into a bubble
//   dm_addr               r1 (memory address / ALU result)
//   dm_wdata              registered forwarded operand B (store data)
//   dm_en, dm_rw          registered memory controls
//   wb_data               r2 (write-back value)
//   zero, alu_ovf         registered flags of the last ALU operation
module exec_forward_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    op_dec,
  input  logic [15:0]   imm,
  input  logic          imm_sel,
  input  logic [1:0]    mux_sel_A,
  input  logic [1:0]    mux_sel_B,
  input  logic [DW-1:0] rf_data_A,
  input  logic [DW-1:0] rf_data_B,
  input  logic          mem_en_ex,
  input  logic          mem_rw_ex,
  input  logic          dm_load,
  input  logic [DW-1:0] dm_rdata,
  input  logic          flush,
  output logic [DW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          dm_en,
  output logic          dm_rw,
  output logic [DW-1:0] wb_data,
  output logic          zero,
  output logic          alu_ovf
);

  typedef enum logic [2:0] {
    FN_ADD = 3'b000,
    FN_SUB = 3'b001,
    FN_AND = 3'b010,
    FN_OR  = 3'b011,
    FN_XOR = 3'b100,
    FN_SLT = 3'b101,
    FN_SLL = 3'b110,
    FN_SRL = 3'b111
  } alu_fn_t;

  logic [DW-1:0] r1, r2, r3;
  logic [DW-1:0] opnd_a, b_fwd, opnd_b, imm_ext, result;
  logic          ovf;
  alu_fn_t       fn;

  assign imm_ext = {{(DW-16){imm[15]}}, imm};

  // Operand selection. Forwarding on B still happens when the immediate is
  // used, because the forwarded value is what a store writes to memory.
  always_comb begin
    opnd_a = rf_data_A;
    unique case (mux_sel_A)
      2'b00: opnd_a = rf_data_A;
      2'b01: opnd_a = r1;
      2'b10: opnd_a = r2;
      2'b11: opnd_a = r3;
    endcase
    b_fwd = rf_data_B;
    unique case (mux_sel_B)
      2'b00: b_fwd = rf_data_B;
      2'b01: b_fwd = r1;
      2'b10: b_fwd = r2;
      2'b11: b_fwd = r3;
    endcase
    opnd_b = imm_sel ? imm_ext : b_fwd;
  end

  // Load/store/jump group always computes an address, so it is forced to ADD.
  always_comb begin
    fn = alu_fn_t'(op_dec[2:0]);
    if (op_dec[5:4] == 2'b01) fn = FN_ADD;
  end

  // ALU. Overflow is only meaningful for ADD/SUB; SUB compares against ~B's
  // sign, i.e. A and B having different signs.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    unique case (fn)
      FN_ADD: begin
        result = opnd_a + opnd_b;
        ovf    = (opnd_a[DW-1] == opnd_b[DW-1]) && (result[DW-1] != opnd_a[DW-1]);
      end
      FN_SUB: begin
        result = opnd_a - opnd_b;
        ovf    = (opnd_a[DW-1] != opnd_b[DW-1]) && (result[DW-1] != opnd_a[DW-1]);
      end
      FN_AND: result = opnd_a & opnd_b;
      FN_OR:  result = opnd_a | opnd_b;
      FN_XOR: result = opnd_a ^ opnd_b;
      FN_SLT: result = {{(DW-1){1'b0}}, ($signed(opnd_a) < $signed(opnd_b))};
      FN_SLL: result = opnd_a << opnd_b[4:0];
      FN_SRL: result = opnd_a >> opnd_b[4:0];
    endcase
  end

  // History and output registers. A flush only kills the EX instruction;
  // older results in r2/r3 keep moving so their consumers still see them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r1       <= '0;
      r2       <= '0;
      r3       <= '0;
      dm_wdata <= '0;
      dm_en    <= 1'b0;
      dm_rw    <= 1'b0;
      zero     <= 1'b0;
      alu_ovf  <= 1'b0;
    end else begin
      r2       <= dm_load ? dm_rdata : r1;
      r3       <= r2;
      dm_wdata <= b_fwd;
      if (flush) begin
        r1      <= '0;
        dm_en   <= 1'b0;
        dm_rw   <= 1'b0;
        zero    <= 1'b1;
        alu_ovf <= 1'b0;
      end else begin
        r1      <= result;
        dm_en   <= mem_en_ex;
        dm_rw   <= mem_rw_ex;
        zero    <= (result == '0);
        alu_ovf <= ovf;
      end
    end
  end

  assign dm_addr = r1;
  assign wb_data = r2;

endmodule

// File: tb/tb_exec_forward_stage.sv
// tb_exec_forward_stage
// Table-driven bench for exec_forward_stage. Each record holds one cycle of
// inputs and the outputs expected just after the following rising edge; the
// table is a continuous stream, so expected values follow the r1/r2/r3 history.
module tb_exec_forward_stage;

  localparam int DW = 32;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b000011;
  localparam logic [5:0] OP_XOR = 6'b000100;
  localparam logic [5:0] OP_SLT = 6'b000101;
  localparam logic [5:0] OP_SLL = 6'b000110;
  localparam logic [5:0] OP_SRL = 6'b000111;
  // Memory group with low bits that would otherwise select SRL/SLL.
  localparam logic [5:0] OP_LD  = 6'b010111;
  localparam logic [5:0] OP_ST  = 6'b010110;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    op_dec;
  logic [15:0]   imm;
  logic          imm_sel;
  logic [1:0]    mux_sel_A, mux_sel_B;
  logic [DW-1:0] rf_data_A, rf_data_B;
  logic          mem_en_ex, mem_rw_ex, dm_load, flush;
  logic [DW-1:0] dm_rdata;
  logic [DW-1:0] dm_addr, dm_wdata, wb_data;
  logic          dm_en, dm_rw, zero, alu_ovf;

  exec_forward_stage #(.DW(DW)) dut (
    .clk(clk), .reset(reset), .op_dec(op_dec), .imm(imm), .imm_sel(imm_sel),
    .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B),
    .rf_data_A(rf_data_A), .rf_data_B(rf_data_B),
    .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex),
    .dm_load(dm_load), .dm_rdata(dm_rdata), .flush(flush),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_en(dm_en), .dm_rw(dm_rw),
    .wb_data(wb_data), .zero(zero), .alu_ovf(alu_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [5:0]    op;
    logic [15:0]   im;
    logic          isel;
    logic [1:0]    sa, sb;
    logic [31:0]   rfa, rfb;
    logic          men, mrw, ld;
    logic [31:0]   rdata;
    logic          fl;
    logic [31:0]   e_addr, e_wb, e_wdata;
    logic          e_en, e_rw, e_zero, e_ovf;
  } vec_t;

  localparam int NVEC = 26;
  vec_t tbl [NVEC];
  int vec_count  = 0;
  int miscompares = 0;

  task automatic apply_stimulus(input vec_t v);
    reset     = v.rst;
    op_dec    = v.op;
    imm       = v.im;
    imm_sel   = v.isel;
    mux_sel_A = v.sa;
    mux_sel_B = v.sb;
    rf_data_A = v.rfa;
    rf_data_B = v.rfb;
    mem_en_ex = v.men;
    mem_rw_ex = v.mrw;
    dm_load   = v.ld;
    dm_rdata  = v.rdata;
    flush     = v.fl;
  endtask

  task automatic check_output(input string name, input vec_t v);
    vec_count++;
    if (dm_addr !== v.e_addr || wb_data !== v.e_wb || dm_wdata !== v.e_wdata ||
        dm_en !== v.e_en || dm_rw !== v.e_rw || zero !== v.e_zero || alu_ovf !== v.e_ovf) begin
      miscompares++;
      $display("[TB] FAIL %s: got addr=%h wb=%h wdata=%h en=%b rw=%b zero=%b ovf=%b, want addr=%h wb=%h wdata=%h en=%b rw=%b zero=%b ovf=%b",
               name, dm_addr, wb_data, dm_wdata, dm_en, dm_rw, zero, alu_ovf,
               v.e_addr, v.e_wb, v.e_wdata, v.e_en, v.e_rw, v.e_zero, v.e_ovf);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    apply_stimulus(v);
    @(posedge clk);
    #1;
    check_output(name, v);
  endtask

  initial begin
    vec_t rv;

    //            rst   op      imm       isel  sa     sb     rfa           rfb           men   mrw   ld    rdata         fl      addr          wb            wdata         en    rw    zero  ovf
    tbl[0]  = '{1'b0, OP_ADD, 16'h0000, 1'b0, 2'b00, 2'b00, 32'd5,        32'd7,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'd12,       32'd0,        32'd7,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, OP_ADD, 16'h0000, 1'b0, 2'b00, 2'b00, 32'd3,        32'd4,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'd7,        32'd12,       32'd4,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, OP_SUB, 16'h0000, 1'b0, 2'b01, 2'b00, 32'd99,       32'd2,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'd5,        32'd7,        32'd2,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, OP_ADD, 16'h0000, 1'b0, 2'b10, 2'b00, 32'd99,       32'd0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'd7,        32'd5,        32'd0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, OP_ADD, 16'h0000, 1'b0, 2'b11, 2'b00, 32'd99,       32'd1,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'd8,        32'd7,        32'd1,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, OP_AND, 16'h0000, 1'b0, 2'b01, 2'b01, 32'd99,       32'd99,       1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'd8,        32'd8,        32'd8,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, OP_XOR, 16'h0000, 1'b0, 2'b00, 2'b10, 32'hF0F0F0F0, 32'd99,       1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'hF0F0F0F8, 32'd8,        32'd8,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, OP_LD,  16'h0010, 1'b1, 2'b00, 2'b00, 32'h100,      32'h33,       1'b1, 1'b0, 1'b0, 32'h0,        1'b0,   32'h110,      32'hF0F0F0F8, 32'h33,       1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, OP_SUB, 16'h0000, 1'b0, 2'b00, 2'b00, 32'd10,       32'd3,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0,   32'd7,        32'hDEADBEEF, 32'd3,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, OP_ADD, 16'h0000, 1'b0, 2'b10, 2'b00, 32'd99,       32'd1,        1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0,   32'hDEADBEF0, 32'd7,        32'd1,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, OP_OR,  16'h0000, 1'b0, 2'b11, 2'b00, 32'd99,       32'd0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'hDEADBEEF, 32'hDEADBEF0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, OP_ADD, 16'hFFFF, 1'b1, 2'b00, 2'b00, 32'd1,        32'h55,       1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'd0,        32'hDEADBEEF, 32'h55,       1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, OP_ADD, 16'h0001, 1'b1, 2'b10, 2'b11, 32'd99,       32'd99,       1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'hDEADBEF0, 32'd0,        32'hDEADBEF0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, OP_ADD, 16'h0000, 1'b0, 2'b00, 2'b00, 32'h7FFFFFFF, 32'd1,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'h80000000, 32'hDEADBEF0, 32'd1,        1'b0, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, OP_SUB, 16'h0000, 1'b0, 2'b00, 2'b00, 32'h80000000, 32'd1,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'h7FFFFFFF, 32'h80000000, 32'd1,        1'b0, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, OP_SLL, 16'h0000, 1'b0, 2'b00, 2'b00, 32'd1,        32'd31,       1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'h80000000, 32'h7FFFFFFF, 32'd31,       1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, OP_SRL, 16'h0000, 1'b0, 2'b01, 2'b00, 32'd99,       32'd31,       1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'd1,        32'h80000000, 32'd31,       1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, OP_SLT, 16'h0000, 1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'd1,        32'd1,        32'd1,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, OP_SLT, 16'h0000, 1'b0, 2'b00, 2'b00, 32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[19] = '{1'b0, OP_ST,  16'h0004, 1'b1, 2'b00, 2'b00, 32'h200,      32'hA5A5,     1'b1, 1'b1, 1'b0, 32'h0,        1'b0,   32'h204,      32'd0,        32'hA5A5,     1'b1, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b0, OP_ST,  16'h0004, 1'b1, 2'b00, 2'b00, 32'h200,      32'hA5A5,     1'b1, 1'b1, 1'b0, 32'h0,        1'b1,   32'd0,        32'h204,      32'hA5A5,     1'b0, 1'b0, 1'b1, 1'b0};
    tbl[21] = '{1'b0, OP_ADD, 16'h0000, 1'b0, 2'b00, 2'b00, 32'h7FFFFFFF, 32'd1,        1'b1, 1'b1, 1'b1, 32'h1234,     1'b1,   32'd0,        32'h1234,     32'd1,        1'b0, 1'b0, 1'b1, 1'b0};
    tbl[22] = '{1'b0, OP_SLL, 16'h0000, 1'b0, 2'b00, 2'b00, 32'd3,        32'h21,       1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'd6,        32'd0,        32'h21,       1'b0, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{1'b0, OP_ADD, 16'h0000, 1'b0, 2'b11, 2'b00, 32'd99,       32'd0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'h1234,     32'd6,        32'd0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[24] = '{1'b1, OP_ADD, 16'h0000, 1'b0, 2'b00, 2'b00, 32'h7FFFFFFF, 32'd1,        1'b1, 1'b1, 1'b1, 32'h55,       1'b1,   32'd0,        32'd0,        32'd0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[25] = '{1'b0, OP_ADD, 16'h0000, 1'b0, 2'b01, 2'b10, 32'd0,        32'd0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0,   32'd0,        32'd0,        32'd0,        1'b0, 1'b0, 1'b1, 1'b0};

    // Power-on reset held for two edges with arbitrary inputs, flush included.
    for (int i = 0; i < 2; i++) begin
      rv.rst   = 1'b1;
      rv.op    = 6'($urandom);
      rv.im    = 16'($urandom);
      rv.isel  = 1'($urandom);
      rv.sa    = 2'($urandom);
      rv.sb    = 2'($urandom);
      rv.rfa   = $urandom;
      rv.rfb   = $urandom;
      rv.men   = 1'($urandom);
      rv.mrw   = 1'($urandom);
      rv.ld    = 1'($urandom);
      rv.rdata = $urandom;
      rv.fl    = 1'($urandom);
      rv.e_addr = '0; rv.e_wb = '0; rv.e_wdata = '0;
      rv.e_en = 1'b0; rv.e_rw = 1'b0; rv.e_zero = 1'b0; rv.e_ovf = 1'b0;
      run_vec($sformatf("reset_hold%0d", i), rv);
    end

    for (int i = 0; i < NVEC; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/exec_forward_stage.md
# exec_forward_stage

Execute stage of the 5-bit-register MIPS-style pipeline. Sits directly downstream of the dependence check block. Selects each ALU operand from either the register file or one of three in-flight result history registers (R1/R2/R3), using that block's `mux_sel_A`/`mux_sel_B`. Computes the ALU result and registers it, and drives the data-memory stage with the address, store data and control.

## Interface
Parameters:
- `DW`, 32, datapath width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `op_dec`  in  6  opcode of the instruction in EX.
- `imm`  in  16  immediate field; sign-extended to DW.
- `imm_sel`  in  1  1 = operand B is the extended immediate.
- `mux_sel_A`, `mux_sel_B`  in  2 each  operand source: 00 = register file, 01 = R1, 10 = R2, 11 = R3.
- `rf_data_A`, `rf_data_B`  in  DW each  register-file read data.
- `mem_en_ex`, `mem_rw_ex`  in  1 each  memory enable / 1 = write, for the EX instruction.
- `dm_load`  in  1  1 = the instruction currently in R1 is a load; aligned with R1.
- `dm_rdata`  in  DW  data-memory read data for the instruction in R1.
- `flush`  in  1  turns the EX instruction into a bubble.
- `dm_addr`  out  DW  equals R1.
- `dm_wdata`  out  DW  registered operand B value (pre-immediate).
- `dm_en`, `dm_rw`  out  1 each  registered memory controls.
- `wb_data`  out  DW  equals R2, the write-back value.
- `zero`  out  1  registered: last ALU result == 0.
- `alu_ovf`  out  1  registered signed overflow of the last ADD/SUB.

## Operation
Operand select (combinational):
- A = rf_data_A / R1 / R2 / R3 per `mux_sel_A`.
- Bfwd is chosen the same way per `mux_sel_B`.
- B = `imm_sel` ? sext(imm) : Bfwd.
- Forwarding applies even when `imm_sel`=1; only B is replaced.

ALU function:
- `op_dec[5:4]==01` (load/store/jump group): function is forced to ADD.
- Otherwise the function comes from `op_dec[2:0]`:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
  - 101 SLT: signed compare, result 1 or 0.
  - 110 SLL, 111 SRL: shift A by B[4:0], logical.
- ADD/SUB wrap modulo 2^DW.
- Overflow = operand signs equal (SUB: A and ~B) and result sign differs. Overflow is 0 for every other function.

History registers, on every clock:
- R1 <= ALU result.
- R2 <= `dm_load` ? dm_rdata : R1.
- R3 <= R2.
- `dm_wdata` <= Bfwd; `dm_en` <= mem_en_ex; `dm_rw` <= mem_rw_ex; `zero` <= (result==0); `alu_ovf` <= ovf.

`flush`=1:
- R1, `dm_en`, `dm_rw`, `alu_ovf` load 0; `zero` loads 1.
- R2 and R3 still shift normally.
- `flush` overrides `mem_en_ex`, so a flushed store never reaches memory.

Reset:
- R1, R2, R3, `dm_wdata`, `dm_en`, `dm_rw`, `zero`, `alu_ovf` all 0.
- Therefore `dm_addr`, `wb_data` = 0.
- Reset has priority over `flush` and over all data.

## Timing
- EX-to-R1 latency is 1 cycle. R2 holds that result 2 cycles after issue, R3 3 cycles after.
- Forwarding distance: a result issued in cycle N is selectable as 01 in N+1, 10 in N+2, 11 in N+3.
- Load data enters the forwarding path one cycle after its address. An issue-adjacent load-use (sel 01 on a load) gets the address, not the data. Upstream must not issue that case; no interlock is done here.
- Same source on A and B: legal; both operands get the same value.
- Reset asserted mid-stream clears all history in one edge. With rf inputs 0, the first post-reset instruction sees zeros from every source.
- `dm_rdata` is sampled only on edges where `dm_load`=1.

## Test plan
- Reset: hold `reset` 2 cycles with random inputs → all outputs 0, including `zero`=0. Release, issue ADD rf 5+7 → `dm_addr`=12 next cycle.
- Back-to-back forwarding: ADD 3+4, then SUB with sel_A=01, rf_B=2 → R1=7 then 5. A third op with sel_A=10 sees 7; a fourth op with sel_A=11 sees 7.
- Load forwarding: LD with `imm`=0x10, rf_A=0x100 → `dm_addr`=0x110. Next cycle `dm_load`=1, `dm_rdata`=0xDEADBEEF → `wb_data`=0xDEADBEEF. An op with sel_A=10 in that cycle sees 0xDEADBEEF.
- Immediate sign-extension and overflow:
  - ADD with imm=0xFFFF, rf_A=1, `imm_sel`=1 → 0, `zero`=1.
  - ADD 0x7FFFFFFF+1 → 0x80000000, `alu_ovf`=1.
- Store and flush:
  - ST with rf_B=0xA5A5 → `dm_wdata`=0xA5A5, `dm_en`=1, `dm_rw`=1.
  - Same store with `flush`=1 → `dm_en`=0, R1=0, `zero`=1.
- Shift/compare: SLL 1 by 31 → 0x80000000; SRL 0x80000000 by 31 → 1; SLT −1 vs 1 → 1; SLT 1 vs −1 → 0.
